// File: rtl/sr_mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and one shared single-port memory.
// The arbiter uses the slave modport; requesters and the memory model use master.
interface sr_mem_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt, rvalid, rdata, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt, rvalid, rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/sr_mem_arbiter.sv
// Two-requester arbiter for one shared memory: round-robin with a burst limit,
// or strict requester-0 priority when SR_ARB_FIXED_PRIO_EN is defined.
module sr_mem_arbiter #(
  parameter int unsigned BURST_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  sr_mem_arbiter_if.slave  bus
);
  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        rr_r;
  logic [1:0]  pend_r;
  logic [1:0]  gnt_s;
  logic [1:0]  rvalid_s;
  logic [31:0] mem_addr_s;
  logic        mem_we_s;
  logic [31:0] mem_wdata_s;

  // grant decision for the current cycle
  always_comb begin
    gnt_s = 2'b00;
    if (rst) begin
      gnt_s = 2'b00;
    end else begin
      case (bus.req)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11: begin
`ifdef SR_ARB_FIXED_PRIO_EN
          gnt_s = 2'b01;
`else
          case (state_r)
            OWN0:    gnt_s = (cnt_r >= BMAX) ? 2'b10 : 2'b01;
            OWN1:    gnt_s = (cnt_r >= BMAX) ? 2'b01 : 2'b10;
            default: gnt_s = rr_r ? 2'b10 : 2'b01;
          endcase
`endif
        end
        default: gnt_s = 2'b00;
      endcase
    end
  end

  // route the granted requester onto the memory port, zeros when idle
  always_comb begin
    mem_addr_s  = 32'd0;
    mem_we_s    = 1'b0;
    mem_wdata_s = 32'd0;
    case (gnt_s)
      2'b01: begin
        mem_addr_s  = bus.addr0;
        mem_we_s    = bus.we[0];
        mem_wdata_s = bus.wdata0;
      end
      2'b10: begin
        mem_addr_s  = bus.addr1;
        mem_we_s    = bus.we[1];
        mem_wdata_s = bus.wdata1;
      end
      default: begin
        mem_addr_s  = 32'd0;
        mem_we_s    = 1'b0;
        mem_wdata_s = 32'd0;
      end
    endcase
  end

  // ownership state, burst counter, tie-break pointer and pending-read flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      rr_r    <= 1'b0;
      pend_r  <= 2'b00;
    end else begin
      pend_r <= gnt_s & ~bus.we;
      case (gnt_s)
        2'b01: begin
          if (state_r == OWN0) begin
            if (cnt_r < BMAX) cnt_r <= cnt_r + 4'd1;
          end else begin
            state_r <= OWN0;
            cnt_r   <= 4'd1;
            // a hand-over forced by a lapsed request leaves the pointer alone
            if (state_r == IDLE || bus.req == 2'b11) rr_r <= 1'b1;
          end
        end
        2'b10: begin
          if (state_r == OWN1) begin
            if (cnt_r < BMAX) cnt_r <= cnt_r + 4'd1;
          end else begin
            state_r <= OWN1;
            cnt_r   <= 4'd1;
            if (state_r == IDLE || bus.req == 2'b11) rr_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  // a read return is suppressed while reset is held
  assign rvalid_s      = rst ? 2'b00 : pend_r;
  assign bus.gnt       = gnt_s;
  assign bus.rvalid    = rvalid_s;
  assign bus.rdata     = (|rvalid_s) ? bus.mem_rdata : 32'd0;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_wdata = mem_wdata_s;
endmodule

// File: tb/tb_sr_mem_arbiter.sv
// Self-checking bench for sr_mem_arbiter: directed vector table, burst sequence,
// then randomized traffic against an ownership/burst reference model.
module tb_sr_mem_arbiter;
  localparam int BM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sr_mem_arbiter_if bus ();
  sr_mem_arbiter #(.BURST_MAX(BM)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: who owns the memory, how long, who wins the next tie, queued read
  int m_owner = -1;
  int m_burst = 0;
  int m_pref  = 0;
  int m_pend  = -1;

  typedef struct {
    logic        r;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [31:0] mrd;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic        mwe;
    logic [31:0] mwdata;
  } vec_t;

  vec_t tbl[13];
  int   seq_exp[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] wd0, input logic [31:0] wd1, input logic [31:0] mrd);
    rst           = r;
    bus.req       = rq;
    bus.we        = w;
    bus.addr0     = a0;
    bus.addr1     = a1;
    bus.wdata0    = wd0;
    bus.wdata1    = wd1;
    bus.mem_rdata = mrd;
  endtask

  function automatic int model_grant();
    if (rst || bus.req == 2'b00) return -1;
    if (bus.req == 2'b01) return 0;
    if (bus.req == 2'b10) return 1;
`ifdef SR_ARB_FIXED_PRIO_EN
    return 0;
`else
    if (m_owner < 0) return m_pref;
    return (m_burst < BM) ? m_owner : 1 - m_owner;
`endif
  endfunction

  // clock edge, then fold this cycle's outcome into the model
  task automatic tick(input int g);
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_burst = 0; m_pref = 0; m_pend = -1;
    end else begin
      m_pend = (g >= 0 && bus.we[g] == 1'b0) ? g : -1;
      if (g < 0) begin
        m_owner = -1; m_burst = 0;
      end else if (g == m_owner) begin
        if (m_burst < BM) m_burst++;
      end else begin
        if (m_owner < 0 || bus.req == 2'b11) m_pref = 1 - g;
        m_owner = g; m_burst = 1;
      end
    end
    #1;
  endtask

  task automatic model_check();
    int          g;
    logic [1:0]  egnt, erv;
    logic [31:0] eaddr, ewd, erd;
    logic        ewe;
    g     = model_grant();
    egnt  = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    eaddr = (g < 0) ? 32'd0 : ((g == 0) ? bus.addr0 : bus.addr1);
    ewd   = (g < 0) ? 32'd0 : ((g == 0) ? bus.wdata0 : bus.wdata1);
    ewe   = (g < 0) ? 1'b0 : bus.we[g];
    erv   = (!rst && m_pend >= 0) ? ((m_pend == 0) ? 2'b01 : 2'b10) : 2'b00;
    erd   = (erv != 2'b00) ? bus.mem_rdata : 32'd0;
    check("rnd_gnt",       {30'd0, bus.gnt},    {30'd0, egnt});
    check("rnd_mem_addr",  bus.mem_addr,        eaddr);
    check("rnd_mem_we",    {31'd0, bus.mem_we}, {31'd0, ewe});
    check("rnd_mem_wdata", bus.mem_wdata,       ewd);
    check("rnd_rvalid",    {30'd0, bus.rvalid}, {30'd0, erv});
    check("rnd_rdata",     bus.rdata,           erd);
    tick(g);
  endtask

  initial begin
    int g;
    //        r     req    we     a0      a1      wd0     wd1     mrd        gnt    rvalid rdata       maddr   mwe   mwdata
    tbl[0]  = '{1'b1, 2'b11, 2'b00, 32'h10, 32'h20, 32'h1,  32'h2,  32'h0,     2'b00, 2'b00, 32'h0,      32'h0,  1'b0, 32'h0};
    tbl[1]  = '{1'b1, 2'b01, 2'b00, 32'h10, 32'h0,  32'h0,  32'h0,  32'h0,     2'b00, 2'b00, 32'h0,      32'h0,  1'b0, 32'h0};
    tbl[2]  = '{1'b0, 2'b01, 2'b00, 32'h10, 32'h0,  32'h0,  32'h0,  32'h0,     2'b01, 2'b00, 32'h0,      32'h10, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,  32'h0,  32'hCAFE,  2'b00, 2'b01, 32'hCAFE,   32'h0,  1'b0, 32'h0};
    tbl[4]  = '{1'b0, 2'b01, 2'b01, 32'h20, 32'h0,  32'h55, 32'h0,  32'h0,     2'b01, 2'b00, 32'h0,      32'h20, 1'b1, 32'h55};
    tbl[5]  = '{1'b0, 2'b10, 2'b00, 32'h0,  32'h20, 32'h0,  32'h0,  32'h0,     2'b10, 2'b00, 32'h0,      32'h20, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,  32'h0,  32'h55,    2'b00, 2'b10, 32'h55,     32'h0,  1'b0, 32'h0};
    tbl[7]  = '{1'b1, 2'b01, 2'b00, 32'h30, 32'h0,  32'h0,  32'h0,  32'h99,    2'b00, 2'b00, 32'h0,      32'h0,  1'b0, 32'h0};
    tbl[8]  = '{1'b0, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,  32'h0,  32'hABC,   2'b00, 2'b00, 32'h0,      32'h0,  1'b0, 32'h0};
    tbl[9]  = '{1'b0, 2'b11, 2'b00, 32'h40, 32'h44, 32'h0,  32'h0,  32'h0,     2'b01, 2'b00, 32'h0,      32'h40, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 2'b10, 2'b00, 32'h0,  32'h44, 32'h0,  32'h0,  32'h1234,  2'b10, 2'b01, 32'h1234,   32'h44, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,  32'h0,  32'h77,    2'b00, 2'b00, 32'h0,      32'h0,  1'b0, 32'h0};
    tbl[12] = '{1'b0, 2'b00, 2'b00, 32'h0,  32'h0,  32'h0,  32'h0,  32'h88,    2'b00, 2'b00, 32'h0,      32'h0,  1'b0, 32'h0};
`ifdef SR_ARB_FIXED_PRIO_EN
    seq_exp = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    seq_exp = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
`endif

    drive(1'b1, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;

    // directed vectors: reset state, single read, write/read alternation, reset over a read
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].r, tbl[i].req, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].wd0, tbl[i].wd1, tbl[i].mrd);
      #3;
      check($sformatf("vec%0d_gnt", i),       {30'd0, bus.gnt},    {30'd0, tbl[i].gnt});
      check($sformatf("vec%0d_rvalid", i),    {30'd0, bus.rvalid}, {30'd0, tbl[i].rvalid});
      check($sformatf("vec%0d_rdata", i),     bus.rdata,           tbl[i].rdata);
      check($sformatf("vec%0d_mem_addr", i),  bus.mem_addr,        tbl[i].maddr);
      check($sformatf("vec%0d_mem_we", i),    {31'd0, bus.mem_we}, {31'd0, tbl[i].mwe});
      check($sformatf("vec%0d_mem_wdata", i), bus.mem_wdata,       tbl[i].mwdata);
      g = model_grant();
      tick(g);
    end

    // burst sequence: requester 0 alone for three grants, then both contend for twelve
    drive(1'b1, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    tick(-1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b01, 2'b11, 32'h100, 32'h200, 32'h1, 32'h2, 32'd0);
      #3;
      check($sformatf("pre%0d_gnt", i), {30'd0, bus.gnt}, 32'd1);
      g = model_grant();
      tick(g);
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 2'b11, 2'b11, 32'h100, 32'h200, 32'h1, 32'h2, 32'd0);
      #3;
      check($sformatf("burst%0d_gnt", i), {30'd0, bus.gnt}, (seq_exp[i] == 0) ? 32'd1 : 32'd2);
      g = model_grant();
      tick(g);
    end

    // randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0, 2'($urandom), 2'($urandom),
            $urandom, $urandom, $urandom, $urandom, $urandom);
      #3;
      model_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
